// File: rtl/spmv_mac_engine.sv
// Sparse-row x dense-vector MAC engine: streams (value, column) words from port A,
// gathers dense operands on port B, and accumulates one signed row dot-product.
module spmv_mac_engine #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned ACC_W   = 72
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     accum_keep,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          nnz,
  output logic                     busy,
  output logic                     done,
  output logic                     ena,
  output logic [ADDR_W-1:0]        addra,
  input  logic [DATA_W+ADDR_W-1:0] dina,
  output logic                     enb,
  output logic [ADDR_W-1:0]        addrb,
  input  logic [DATA_W-1:0]        dinb,
  output logic [ACC_W-1:0]         acc_out,
  output logic                     acc_valid
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic [MUL_LAT-1:0] M_LAST = MUL_LAT'(1) << (MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                   state, state_nx;
  logic                     busy_nx, done_nx, ena_nx, acc_valid_nx, acc_clr;
  logic [ADDR_W-1:0]        addra_nx;
  logic [CNT_W-1:0]         idx, idx_nx, last_idx, last_nx;

  logic [RD_LAT-1:0]        a_vld, b_vld;
  logic signed [DATA_W-1:0] val_d [RD_LAT];
  logic [ADDR_W-1:0]        addrb_q;
  logic                     op_vld;
  logic signed [DATA_W-1:0] op_a, op_b;
  logic [MUL_LAT-1:0]       m_vld;
  logic signed [PROD_W-1:0] prod [MUL_LAT];
  logic signed [ACC_W-1:0]  prod_ext;
  logic                     pipe_busy;

  // Pipeline is empty next cycle once only the final product stage may still hold data.
  assign pipe_busy = (|a_vld) | (|b_vld) | op_vld | (|(m_vld & ~M_LAST));

  // Dense fetch is issued straight off the sparse read return.
  assign enb      = a_vld[RD_LAT-1];
  assign addrb    = enb ? dina[ADDR_W-1:0] : addrb_q;
  assign prod_ext = ACC_W'(prod[MUL_LAT-1]);

  // Next-state and next-output logic
  always_comb begin
    state_nx     = state;
    busy_nx      = busy;
    done_nx      = 1'b0;
    ena_nx       = 1'b0;
    addra_nx     = addra;
    idx_nx       = idx;
    last_nx      = last_idx;
    acc_clr      = 1'b0;
    acc_valid_nx = acc_valid;
    unique case (state)
      IDLE: begin
        if (start) begin
          last_nx      = nnz - CNT_W'(1);
          idx_nx       = '0;
          acc_clr      = ~accum_keep;
          acc_valid_nx = 1'b0;
          busy_nx      = 1'b1;
          if (nnz != '0) begin
            state_nx = FETCH;
            ena_nx   = 1'b1;
            addra_nx = base_addr;
          end else begin
            state_nx     = DONE;
            done_nx      = 1'b1;
            acc_valid_nx = 1'b1;
          end
        end
      end
      FETCH: begin
        if (idx == last_idx) begin
          state_nx = DRAIN;
        end else begin
          ena_nx   = 1'b1;
          addra_nx = addra + ADDR_W'(1);
          idx_nx   = idx + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (!pipe_busy) begin
          state_nx     = DONE;
          done_nx      = 1'b1;
          acc_valid_nx = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered control outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ena       <= 1'b0;
      addra     <= '0;
      idx       <= '0;
      last_idx  <= '0;
      acc_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      ena       <= ena_nx;
      addra     <= addra_nx;
      idx       <= idx_nx;
      last_idx  <= last_nx;
      acc_valid <= acc_valid_nx;
    end
  end

  // Read-return alignment, operand capture and multiplier pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_vld   <= '0;
      b_vld   <= '0;
      addrb_q <= '0;
      op_vld  <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      m_vld   <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) val_d[i] <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) prod[i] <= '0;
    end else begin
      a_vld[0] <= ena;
      b_vld[0] <= enb;
      val_d[0] <= dina[DATA_W+ADDR_W-1:ADDR_W];
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        a_vld[i] <= a_vld[i-1];
        b_vld[i] <= b_vld[i-1];
        val_d[i] <= val_d[i-1];
      end
      if (enb) addrb_q <= dina[ADDR_W-1:0];
      op_vld   <= b_vld[RD_LAT-1];
      op_a     <= val_d[RD_LAT-1];
      op_b     <= dinb;
      m_vld[0] <= op_vld;
      prod[0]  <= PROD_W'(op_a) * PROD_W'(op_b);
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        m_vld[i] <= m_vld[i-1];
        prod[i]  <= prod[i-1];
      end
    end
  end

  // Accumulator wraps modulo 2^ACC_W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_out <= '0;
    end else if (acc_clr) begin
      acc_out <= '0;
    end else if (m_vld[MUL_LAT-1]) begin
      acc_out <= acc_out + $unsigned(prod_ext);
    end
  end

endmodule

// File: tb/tb_spmv_mac_engine.sv
// Self-checking bench for spmv_mac_engine: BRAM models, a 72-bit reference
// accumulator feeding a result queue, and per-scenario checks.
module tb_spmv_mac_engine;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned ACC_W   = 72;
  localparam int unsigned SW_W    = DATA_W + ADDR_W;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset, start, accum_keep;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   nnz;
  logic              busy, done, ena, enb, acc_valid;
  logic [ADDR_W-1:0] addra, addrb;
  logic [SW_W-1:0]   dina;
  logic [DATA_W-1:0] dinb;
  logic [ACC_W-1:0]  acc_out;

  always #5 clk = ~clk;

  spmv_mac_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MUL_LAT(MUL_LAT), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .accum_keep(accum_keep),
    .base_addr(base_addr), .nnz(nnz), .busy(busy), .done(done),
    .ena(ena), .addra(addra), .dina(dina), .enb(enb), .addrb(addrb),
    .dinb(dinb), .acc_out(acc_out), .acc_valid(acc_valid)
  );

  // Block-RAM models with RD_LAT-cycle read latency
  logic [SW_W-1:0]   sparse_mem [DEPTH];
  logic [DATA_W-1:0] dense_mem  [DEPTH];
  logic [SW_W-1:0]   a_pipe [RD_LAT];
  logic [DATA_W-1:0] b_pipe [RD_LAT];

  always @(posedge clk) begin
    if (ena) a_pipe[0] <= sparse_mem[addra];
    if (enb) b_pipe[0] <= dense_mem[addrb];
    for (int i = 1; i < RD_LAT; i++) begin
      a_pipe[i] <= a_pipe[i-1];
      b_pipe[i] <= b_pipe[i-1];
    end
  end
  assign dina = a_pipe[RD_LAT-1];
  assign dinb = b_pipe[RD_LAT-1];

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [ACC_W-1:0] exp_q [$];
  logic [ACC_W-1:0] model_acc;
  int               addra_v [$], addra_c [$], addrb_v [$], addrb_c [$];
  int               done_cyc, n_done;
  logic [ACC_W-1:0] acc_done, acc_hold;
  logic             accv_done, accv_c1, busy_c1;

  function automatic logic [SW_W-1:0] word(input int val, input int idx);
    return {DATA_W'(val), ADDR_W'(idx)};
  endfunction

  function automatic logic [ACC_W-1:0] prod_of(input logic [SW_W-1:0] w);
    logic signed [DATA_W-1:0] v, d;
    logic signed [ACC_W-1:0]  vx, dx;
    v  = w[SW_W-1:ADDR_W];
    d  = dense_mem[w[ADDR_W-1:0]];
    vx = ACC_W'(v);
    dx = ACC_W'(d);
    return vx * dx;
  endfunction

  function automatic int exp_done_cycle(input int n);
    return (n == 0) ? 1 : n + 2 * RD_LAT + MUL_LAT + 2;
  endfunction

  // Drives one row, pushes the reference result, and records port activity per cycle.
  task automatic run_row(input int b, input int n, input logic keep, input int poke);
    addra_v.delete(); addra_c.delete(); addrb_v.delete(); addrb_c.delete();
    n_done = 0; done_cyc = -1; acc_done = '0; accv_done = 1'b0;
    if (!keep) model_acc = '0;
    for (int k = 0; k < n; k++) model_acc += prod_of(sparse_mem[ADDR_W'(b + k)]);
    exp_q.push_back(model_acc);
    @(negedge clk);
    base_addr = ADDR_W'(b); nnz = CNT_W'(n); accum_keep = keep; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 400; c++) begin
      if (c == 1) begin accv_c1 = acc_valid; busy_c1 = busy; end
      if (ena) begin addra_v.push_back(int'(addra)); addra_c.push_back(c); end
      if (enb) begin addrb_v.push_back(int'(addrb)); addrb_c.push_back(c); end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = c; acc_done = acc_out; accv_done = acc_valid; end
      end
      start = (c == poke);
      if (c == poke) begin base_addr = ADDR_W'(100); nnz = CNT_W'(5); end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    acc_hold = acc_out;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; accum_keep = 1'b0; base_addr = '0; nnz = '0;
    repeat (3) @(negedge clk);
    total_cnt++; if ({busy, done, ena, enb, acc_valid} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {busy, done, ena, enb, acc_valid}); else pass_cnt++;
    total_cnt++; if (addra !== '0) $display("FAIL reset_addra: got %0d want 0", addra); else pass_cnt++;
    total_cnt++; if (addrb !== '0) $display("FAIL reset_addrb: got %0d want 0", addrb); else pass_cnt++;
    total_cnt++; if (acc_out !== '0) $display("FAIL reset_acc: got %h want 0", acc_out); else pass_cnt++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if ({busy, ena, done} !== 3'b0) $display("FAIL reset_idle: got %b want 000", {busy, ena, done}); else pass_cnt++;
  endtask

  task automatic test_basic();
    int exp_b [3] = '{5, 1, 7};
    logic [ACC_W-1:0] e;
    run_row(0, 3, 1'b0, 0);
    total_cnt++; if (addra_v.size() != 3) $display("FAIL basic_addra_cnt: got %0d want 3", addra_v.size()); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (k >= addra_v.size() || addra_v[k] != k || addra_c[k] != 1 + k)
        $display("FAIL basic_addra%0d: got %0d@%0d want %0d@%0d", k,
                 (k < addra_v.size()) ? addra_v[k] : -1, (k < addra_c.size()) ? addra_c[k] : -1, k, 1 + k);
      else pass_cnt++;
    end
    total_cnt++; if (addrb_v.size() != 3) $display("FAIL basic_addrb_cnt: got %0d want 3", addrb_v.size()); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (k >= addrb_v.size() || addrb_v[k] != exp_b[k] || addrb_c[k] != 2 + k)
        $display("FAIL basic_addrb%0d: got %0d@%0d want %0d@%0d", k,
                 (k < addrb_v.size()) ? addrb_v[k] : -1, (k < addrb_c.size()) ? addrb_c[k] : -1, exp_b[k], 2 + k);
      else pass_cnt++;
    end
    total_cnt++; if (busy_c1 !== 1'b1 || accv_c1 !== 1'b0) $display("FAIL basic_c1_flags: got busy=%b accv=%b want busy=1 accv=0", busy_c1, accv_c1); else pass_cnt++;
    total_cnt++; if (done_cyc != exp_done_cycle(3)) $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, exp_done_cycle(3)); else pass_cnt++;
    total_cnt++; if (n_done != 1) $display("FAIL basic_done_pulses: got %0d want 1", n_done); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++; if (acc_done !== e) $display("FAIL basic_acc: got %h want %h", acc_done, e); else pass_cnt++;
    total_cnt++; if (acc_done !== ACC_W'(-9)) $display("FAIL basic_acc_const: got %h want -9", acc_done); else pass_cnt++;
    total_cnt++; if (accv_done !== 1'b1) $display("FAIL basic_acc_valid: got %b want 1", accv_done); else pass_cnt++;
    total_cnt++; if (acc_hold !== e || acc_valid !== 1'b1) $display("FAIL basic_hold: got %h/%b want %h/1", acc_hold, acc_valid, e); else pass_cnt++;
  endtask

  task automatic test_zero_nnz();
    logic [ACC_W-1:0] e;
    run_row(10, 1, 1'b0, 0);
    e = exp_q.pop_front();
    total_cnt++; if (acc_done !== e) $display("FAIL prior55_acc: got %h want %h", acc_done, e); else pass_cnt++;
    run_row(0, 0, 1'b0, 0);
    e = exp_q.pop_front();
    total_cnt++; if (done_cyc != 1) $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); else pass_cnt++;
    total_cnt++; if (n_done != 1) $display("FAIL zero_done_pulses: got %0d want 1", n_done); else pass_cnt++;
    total_cnt++; if (acc_done !== e) $display("FAIL zero_acc: got %h want %h", acc_done, e); else pass_cnt++;
    total_cnt++; if (addra_v.size() != 0 || addrb_v.size() != 0) $display("FAIL zero_ports: got ena=%0d enb=%0d want 0/0", addra_v.size(), addrb_v.size()); else pass_cnt++;
  endtask

  task automatic test_keep();
    logic [ACC_W-1:0] e;
    run_row(0, 3, 1'b0, 0);
    e = exp_q.pop_front();
    total_cnt++; if (acc_done !== e) $display("FAIL keep_rowA: got %h want %h", acc_done, e); else pass_cnt++;
    run_row(3, 1, 1'b1, 0);
    e = exp_q.pop_front();
    total_cnt++; if (acc_done !== e) $display("FAIL keep_acc: got %h want %h", acc_done, e); else pass_cnt++;
    total_cnt++; if (acc_done !== ACC_W'(21)) $display("FAIL keep_acc_const: got %h want 21", acc_done); else pass_cnt++;
    total_cnt++; if (done_cyc != exp_done_cycle(1)) $display("FAIL keep_done_cycle: got %0d want %0d", done_cyc, exp_done_cycle(1)); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int exp_a [4] = '{2046, 2047, 0, 1};
    logic [ACC_W-1:0] e;
    run_row(2046, 4, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (k >= addra_v.size() || addra_v[k] != exp_a[k])
        $display("FAIL wrap_addra%0d: got %0d want %0d", k, (k < addra_v.size()) ? addra_v[k] : -1, exp_a[k]);
      else pass_cnt++;
    end
    e = exp_q.pop_front();
    total_cnt++; if (acc_done !== e) $display("FAIL wrap_acc: got %h want %h", acc_done, e); else pass_cnt++;
    total_cnt++; if (done_cyc != exp_done_cycle(4)) $display("FAIL wrap_done_cycle: got %0d want %0d", done_cyc, exp_done_cycle(4)); else pass_cnt++;
  endtask

  task automatic test_wide();
    logic [ACC_W-1:0] e, big;
    big = '0;
    big[64] = 1'b1;
    run_row(20, 4, 1'b0, 0);
    e = exp_q.pop_front();
    total_cnt++; if (acc_done !== e) $display("FAIL wide_acc: got %h want %h", acc_done, e); else pass_cnt++;
    total_cnt++; if (acc_done !== big) $display("FAIL wide_acc_2p64: got %h want %h", acc_done, big); else pass_cnt++;
    run_row(24, 2, 1'b0, 0);
    e = exp_q.pop_front();
    total_cnt++; if (acc_done !== e) $display("FAIL wide_signext: got %h want %h", acc_done, e); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [ACC_W-1:0] e;
    int dn;
    @(negedge clk);
    base_addr = '0; nnz = CNT_W'(8); accum_keep = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total_cnt++; if (ena !== 1'b1) $display("FAIL midrst_fetching: got ena=%b want 1", ena); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++; if ({busy, done, ena, enb, acc_valid} !== 5'b0) $display("FAIL midrst_ctrl: got %b want 00000", {busy, done, ena, enb, acc_valid}); else pass_cnt++;
    total_cnt++; if (addra !== '0 || addrb !== '0 || acc_out !== '0) $display("FAIL midrst_data: got %0d/%0d/%h want 0/0/0", addra, addrb, acc_out); else pass_cnt++;
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 2) reset = 1'b1;
      if (done) dn++;
    end
    total_cnt++; if (dn != 0) $display("FAIL midrst_no_done: got %0d pulses want 0", dn); else pass_cnt++;
    run_row(3, 1, 1'b0, 0);
    e = exp_q.pop_front();
    total_cnt++; if (acc_done !== e || n_done != 1) $display("FAIL midrst_next_row: got %h x%0d want %h x1", acc_done, n_done, e); else pass_cnt++;
  endtask

  task automatic test_busy_start();
    logic [ACC_W-1:0] e;
    run_row(0, 3, 1'b0, 3);
    e = exp_q.pop_front();
    total_cnt++; if (acc_done !== e) $display("FAIL busy_start_acc: got %h want %h", acc_done, e); else pass_cnt++;
    total_cnt++; if (addra_v.size() != 3 || n_done != 1) $display("FAIL busy_start_ignored: got fetches=%0d dones=%0d want 3/1", addra_v.size(), n_done); else pass_cnt++;
    total_cnt++; if (done_cyc != exp_done_cycle(3)) $display("FAIL busy_start_cycle: got %0d want %0d", done_cyc, exp_done_cycle(3)); else pass_cnt++;
    run_row(0, 3, 1'b0, exp_done_cycle(3));
    e = exp_q.pop_front();
    total_cnt++; if (addra_v.size() != 3 || n_done != 1 || busy !== 1'b0) $display("FAIL done_start_ignored: got fetches=%0d dones=%0d busy=%b want 3/1/0", addra_v.size(), n_done, busy); else pass_cnt++;
    total_cnt++; if (acc_hold !== e) $display("FAIL done_start_hold: got %h want %h", acc_hold, e); else pass_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      sparse_mem[i] = '0;
      dense_mem[i]  = '0;
    end
    for (int i = 0; i < int'(RD_LAT); i++) begin
      a_pipe[i] = '0;
      b_pipe[i] = '0;
    end
    sparse_mem[0]    = word(2, 5);
    sparse_mem[1]    = word(-3, 1);
    sparse_mem[2]    = word(4, 7);
    sparse_mem[3]    = word(5, 2);
    for (int k = 4; k < 8; k++) sparse_mem[k] = word(k + 1, k);
    sparse_mem[10]   = word(5, 9);
    sparse_mem[2046] = word(100, 3);
    sparse_mem[2047] = word(-7, 4);
    for (int k = 20; k < 24; k++) sparse_mem[k] = word(32'h8000_0000, 30);
    sparse_mem[24]   = word(32'h8000_0000, 31);
    sparse_mem[25]   = word(-1, 30);
    dense_mem[1]  = DATA_W'(7);
    dense_mem[2]  = DATA_W'(6);
    dense_mem[3]  = DATA_W'(-5);
    dense_mem[4]  = DATA_W'(9);
    dense_mem[5]  = DATA_W'(10);
    dense_mem[6]  = DATA_W'(3);
    dense_mem[7]  = DATA_W'(-2);
    dense_mem[9]  = DATA_W'(11);
    dense_mem[30] = 32'h8000_0000;
    dense_mem[31] = 32'h7FFF_FFFF;
    model_acc = '0;

    test_reset();
    test_basic();
    test_zero_nnz();
    test_keep();
    test_wrap();
    test_wide();
    test_reset_mid();
    test_busy_start();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
